// File: rtl/demux4_stream.sv
// 1-to-4 stream demultiplexer with valid/ready handshake and broadcast mode.
// Each channel owns a one-entry holding register so one stall blocks only its own traffic.
module demux4_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] accept_count
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [3:0] slot_free;
    logic [3:0] sel_oh;
    logic [3:0] tgt;
    logic [3:0] load;
    logic       accept;

    always_comb begin
        slot_free = ~valid_q | out_ready;

        sel_oh = 4'b0000;
        unique case (in_sel)
            2'd0: sel_oh = 4'b0001;
            2'd1: sel_oh = 4'b0010;
            2'd2: sel_oh = 4'b0100;
            2'd3: sel_oh = 4'b1000;
            default: sel_oh = 4'b0000;
        endcase

        // A broadcast is all-or-nothing: every slot must be free at once.
        tgt      = in_bcast ? 4'b1111 : sel_oh;
        in_ready = in_bcast ? (&slot_free) : slot_free[in_sel];
        accept   = in_valid & in_ready;
        load     = accept ? tgt : 4'b0000;

        // A load wins over a same-cycle drain, keeping the slot valid.
        valid_d = load | (valid_q & ~out_ready);

        for (int i = 0; i < 4; i++) begin
            data_d[i] = load[i] ? in_data : data_q[i];
        end

        cnt_d = cnt_q + CNT_W'(accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 4'b0000;
            cnt_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_data0    = data_q[0];
    assign out_data1    = data_q[1];
    assign out_data2    = data_q[2];
    assign out_data3    = data_q[3];
    assign out_valid    = valid_q;
    assign accept_count = cnt_q;

endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
1-to-4 stream demultiplexer with valid/ready handshake; the distribution-side counterpart of the team's 4:1 selectors. Routes each accepted input word to one of four output channels, or to all four in broadcast mode. Each channel has a one-entry holding register, so a stalled consumer blocks only traffic addressed to it. Sits between a single producer and up to four independent consumers.

Parameters:
WIDTH, 4, data width of input and each output channel.
CNT_W, 8, width of the accepted-word counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  WIDTH  input word.
in_sel  input  2  target channel 0..3; ignored when in_bcast=1.
in_bcast  input  1  1 = deliver word to all four channels.
in_valid  input  1  producer has a word.
in_ready  output  1  block can accept this cycle.
out_data0..out_data3  output  WIDTH each  channel data.
out_valid  output  4  bit i = channel i holds a word.
out_ready  input  4  bit i = consumer i takes word this cycle.
accept_count  output  CNT_W  number of accepted input words, modulo 2^CNT_W.

Behaviour:
- State per channel i: data_q[i], valid_q[i]. out_dataI = data_q[i]; out_valid[i] = valid_q[i].
- Reset (synchronous, clk edge with reset=1): valid_q=0000, all data_q=0, accept_count=0. Reset overrides any same-cycle handshake. After reset: in_ready=1.
- slot_free[i] = !valid_q[i] | out_ready[i].
- in_ready, combinational: in_bcast ? (&slot_free) : slot_free[in_sel]. It depends on in_sel, in_bcast, out_ready and valid_q. It does not depend on in_valid.
- Producer rule: once in_valid=1, hold in_data, in_sel and in_bcast stable until accepted.
- Accept = in_valid & in_ready. On accept:
  - Targeted channel(s) load data_q <= in_data and set valid_q <= 1.
  - accept_count += 1, wrapping from 2^CNT_W-1 to 0.
  - Broadcast counts as one accept.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N (one-cycle registered latency).
- Drain: valid_q[i] & out_ready[i] with no same-cycle load to i -> valid_q[i] <= 0. data_q[i] keeps its stale value and is don't-care while invalid.
- Simultaneous drain and load on the same channel: the new word replaces the old one and valid_q[i] stays 1. This gives full throughput, one word per cycle per channel.
- Stall: valid_q[i]=1 & out_ready[i]=0 -> data_q[i] and valid_q[i] are held unchanged. Words for other channels still flow.
- Broadcast with any channel blocked: in_ready=0 and nothing is loaded. Partial broadcast is never performed.
- out_ready[i] while valid_q[i]=0: no effect.
- in_valid=0: no state change except drains.
- No word is ever dropped or duplicated. Each accepted targeted word appears exactly once on exactly one channel; a broadcast appears once on each channel.
- Reset mid-operation: all held words are discarded. Outputs are invalid on the cycle after the reset edge.

Test Plan:
1. Reset for 2 cycles, all inputs 0 -> out_valid=0000, accept_count=0, in_ready=1, out_data0..3=0.
2. Send in_sel=2, data=4'hA with out_ready=0000 -> after 1 edge: out_valid=0100, out_data2=A. Then present sel=2, data=4'hB -> in_ready=0 and B is held. Raise out_ready[2] -> in_ready=1, B loads on that edge, out_valid stays 0100, out_data2=B, accept_count=2.
3. Channel 1 stalled holding 4'h3 (out_ready=1101); present sel=0, data=4'h7 -> accepted, out_valid=0011, out_data0=7. Channel 1 still holds 3.
4. Broadcast 4'h5 while channel 3 is full and out_ready[3]=0 -> in_ready=0 and no channel changes. Raise out_ready[3] -> accepted; next cycle out_valid=1111, all out_data=5, accept_count increments by exactly 1.
5. out_ready=1111, stream sel 0,1,2,3,0 with data 1,2,3,4,5 on consecutive cycles -> in_ready=1 throughout. Each word appears on its channel one cycle later for exactly one cycle; accept_count=5.
6. With words held on channels 0 and 3, assert reset together with in_valid=1 and sel=1 -> after the edge: out_valid=0000, accept_count=0, no load on channel 1. Separately, 256 consecutive accepts from reset -> accept_count wraps to 0.
